// File: rtl/cvp14_mem_sys_if.sv
// Core bus and boot-loader port of the CVP14 unified memory subsystem.
// The master side is the core plus the loader; the slave side is the memory.
interface cvp14_mem_sys_if;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic        V;
  logic [15:0] DataOut;
  logic [15:0] DataIn;
  // Loader handshake: a word transfers on any rising Clk1 edge where
  // ld_valid and ld_ready are both high. ld_ready is combinational and drops
  // while the core drives RD or WR. The master keeps ld_valid, ld_addr and
  // ld_data stable until it sees the transfer.
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;

  modport master (
    output Addr, RD, WR, V, DataOut, ld_valid, ld_addr, ld_data,
    input  DataIn, ld_ready
  );
  modport slave (
    input  Addr, RD, WR, V, DataOut, ld_valid, ld_addr, ld_data,
    output DataIn, ld_ready
  );
endinterface

// File: rtl/cvp14_mem_sys.sv
// CVP14 unified 16-bit word memory: one-cycle registered read, loader port, sticky status.
// Optional macro CVP14_MEM_CHECK_EN: flag and block accesses whose upper address bits are nonzero.
module cvp14_mem_sys #(
  parameter int ADDR_W    = 10,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 Clk1,
  input  logic                 Reset,
  cvp14_mem_sys_if.slave       bus,
  output logic                 ovf_sticky,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output logic                 err_proto,
  output logic                 err_oob
);
  localparam int DEPTH = 1 << ADDR_W;

  // No reset on the array: contents must survive Reset for boot-loaded code.
  logic [15:0] mem [0:DEPTH-1];

  logic              core_rd;
  logic              core_wr;
  logic              core_acc;
  logic              ld_fire;
  logic              core_oob;
  logic              ld_oob;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       wdata;
  logic              v_q;

`ifdef CVP14_MEM_CHECK_EN
  assign core_oob = |bus.Addr[15:ADDR_W];
  assign ld_oob   = |bus.ld_addr[15:ADDR_W];
`else
  assign core_oob = 1'b0;
  assign ld_oob   = 1'b0;
  wire unused_hi = ^{bus.Addr[15:ADDR_W], bus.ld_addr[15:ADDR_W]};
`endif

  assign bus.ld_ready = Reset | (~bus.RD & ~bus.WR);

  // A simultaneous RD/WR is treated as a write; the read half is dropped.
  assign core_rd  = ~Reset & bus.RD & ~bus.WR;
  assign core_wr  = ~Reset & bus.WR;
  assign core_acc = core_rd | core_wr;
  assign ld_fire  = bus.ld_valid & bus.ld_ready;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (core_wr) begin
      we    = ~core_oob;
      waddr = bus.Addr[ADDR_W-1:0];
      wdata = bus.DataOut;
    end else if (ld_fire) begin
      we    = ~ld_oob;
      waddr = bus.ld_addr[ADDR_W-1:0];
      wdata = bus.ld_data;
    end
  end

  always_ff @(posedge Clk1) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      bus.DataIn <= '0;
    end else if (core_rd) begin
      bus.DataIn <= core_oob ? 16'h0000 : mem[bus.Addr[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      v_q        <= 1'b0;
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
      err_proto  <= 1'b0;
    end else begin
      v_q <= bus.V;
      if (bus.V) ovf_sticky <= 1'b1;
      if (bus.V && !v_q && !(&ovf_count))
        ovf_count <= ovf_count + {{(OVF_CNT_W-1){1'b0}}, 1'b1};
      if (bus.RD && bus.WR) err_proto <= 1'b1;
    end
  end

`ifdef CVP14_MEM_CHECK_EN
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      err_oob <= 1'b0;
    end else if ((core_acc && core_oob) || (ld_fire && ld_oob)) begin
      err_oob <= 1'b1;
    end
  end
`else
  assign err_oob = 1'b0;
`endif
endmodule

// File: tb/tb_cvp14_mem_sys.sv
// Directed bench for cvp14_mem_sys: behavioural memory/status model checked every cycle,
// plus literal expectations for the boot, burst, arbitration, error, overflow and range cases.
module tb_cvp14_mem_sys;
  localparam int ADDR_W    = 10;
  localparam int OVF_CNT_W = 8;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int CNT_MAX   = (1 << OVF_CNT_W) - 1;

  logic                 Clk1;
  logic                 Reset;
  logic                 ovf_sticky;
  logic [OVF_CNT_W-1:0] ovf_count;
  logic                 err_proto;
  logic                 err_oob;

  cvp14_mem_sys_if bus ();

  cvp14_mem_sys #(.ADDR_W(ADDR_W), .OVF_CNT_W(OVF_CNT_W)) dut (
    .Clk1       (Clk1),
    .Reset      (Reset),
    .bus        (bus),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count),
    .err_proto  (err_proto),
    .err_oob    (err_oob)
  );

  // Clock / reset block
  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: word array plus status, updated from the bus rules at each edge
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_data;
  bit          m_sticky, m_proto, m_oob, m_vq;
  int          m_cnt;

  function automatic bit out_of_range(logic [15:0] a);
`ifdef CVP14_MEM_CHECK_EN
    return int'(a) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge Clk1) begin
    if (Reset) begin
      m_data = 16'h0; m_sticky = 0; m_cnt = 0; m_proto = 0; m_oob = 0; m_vq = 0;
      if (bus.ld_valid && !out_of_range(bus.ld_addr))
        m_mem[int'(bus.ld_addr) % DEPTH] = bus.ld_data;
    end else begin
      if (bus.WR) begin
        if (out_of_range(bus.Addr)) m_oob = 1;
        else m_mem[int'(bus.Addr) % DEPTH] = bus.DataOut;
        if (bus.RD) m_proto = 1;
      end else if (bus.RD) begin
        if (out_of_range(bus.Addr)) begin m_oob = 1; m_data = 16'h0; end
        else m_data = m_mem[int'(bus.Addr) % DEPTH];
      end else if (bus.ld_valid) begin
        if (out_of_range(bus.ld_addr)) m_oob = 1;
        else m_mem[int'(bus.ld_addr) % DEPTH] = bus.ld_data;
      end
      if (bus.V) m_sticky = 1;
      if (bus.V && !m_vq && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      m_vq = bus.V;
    end
  end

  // Scoreboard: expected values queued per cycle, popped against DUT outputs
  logic [31:0] exp_q[$];

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge Clk1) begin
    if (chk_en) begin
      exp_q.push_back({16'h0, m_data});
      exp_q.push_back({31'h0, Reset | (~bus.RD & ~bus.WR)});
      exp_q.push_back({31'h0, m_sticky});
      exp_q.push_back(m_cnt);
      exp_q.push_back({31'h0, m_proto});
      exp_q.push_back({31'h0, m_oob});
      cmp("DataIn",     {16'h0, bus.DataIn},  exp_q.pop_front());
      cmp("ld_ready",   {31'h0, bus.ld_ready}, exp_q.pop_front());
      cmp("ovf_sticky", {31'h0, ovf_sticky},  exp_q.pop_front());
      cmp("ovf_count",  {24'h0, ovf_count},   exp_q.pop_front());
      cmp("err_proto",  {31'h0, err_proto},   exp_q.pop_front());
      cmp("err_oob",    {31'h0, err_oob},     exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge Clk1);
    #2;
  endtask

  task automatic idle();
    bus.RD = 0; bus.WR = 0; bus.V = 0; bus.ld_valid = 0;
  endtask

  task automatic core_rd(logic [15:0] a);
    bus.RD = 1; bus.WR = 0; bus.Addr = a;
    tick();
  endtask

  task automatic core_wr(logic [15:0] a, logic [15:0] d);
    bus.RD = 0; bus.WR = 1; bus.Addr = a; bus.DataOut = d;
    tick();
    bus.WR = 0;
  endtask

  task automatic ld_wr(logic [15:0] a, logic [15:0] d);
    bus.ld_valid = 1; bus.ld_addr = a; bus.ld_data = d;
    tick();
    bus.ld_valid = 0;
  endtask

  initial begin
    Reset = 1;
    bus.Addr = 0; bus.DataOut = 0; bus.ld_addr = 0; bus.ld_data = 0;
    idle();

    // Boot load during Reset
    ld_wr(16'h0000, 16'h4123);
    chk_en = 1'b1;
    cmp("reset_DataIn", {16'h0, bus.DataIn}, 32'h0);
    cmp("reset_ld_ready", {31'h0, bus.ld_ready}, 32'h1);
    ld_wr(16'h0001, 16'h8FFE);
    tick();
    cmp("reset_ovf_count", {24'h0, ovf_count}, 32'h0);
    Reset = 0;
    core_rd(16'h0000);
    cmp("boot_rd0", {16'h0, bus.DataIn}, 32'h4123);
    core_rd(16'h0001);
    cmp("boot_rd1", {16'h0, bus.DataIn}, 32'h8FFE);
    idle();

    // Preload then back-to-back Load burst
    for (int i = 0; i < 16; i++) ld_wr(16'h0010 + 16'(i), 16'h3C00 + 16'(i));
    for (int i = 0; i < 16; i++) begin
      core_rd(16'h0010 + 16'(i));
      cmp("burst", {16'h0, bus.DataIn}, 32'h3C00 + 32'(i));
    end
    idle();

    // Arbitration: loader stalls behind three core reads
    core_wr(16'h0020, 16'h1234);
    bus.ld_valid = 1; bus.ld_addr = 16'h0020; bus.ld_data = 16'hA5A5;
    bus.RD = 1; bus.Addr = 16'h0010; #1;
    cmp("arb_stall0", {31'h0, bus.ld_ready}, 32'h0);
    tick();
    cmp("arb_rd0", {16'h0, bus.DataIn}, 32'h3C00);
    core_rd(16'h0020);
    cmp("arb_rd_old", {16'h0, bus.DataIn}, 32'h1234);
    core_rd(16'h0011);
    cmp("arb_rd2", {16'h0, bus.DataIn}, 32'h3C01);
    bus.RD = 0; #1;
    cmp("arb_ready", {31'h0, bus.ld_ready}, 32'h1);
    tick();
    bus.ld_valid = 0;
    core_rd(16'h0020);
    cmp("arb_landed", {16'h0, bus.DataIn}, 32'hA5A5);
    idle();

    // Protocol error: RD and WR together
    bus.RD = 1; bus.WR = 1; bus.Addr = 16'h0005; bus.DataOut = 16'hBEEF;
    tick();
    cmp("proto_hold", {16'h0, bus.DataIn}, 32'hA5A5);
    cmp("proto_flag", {31'h0, err_proto}, 32'h1);
    idle();
    tick(); tick();
    cmp("proto_sticky", {31'h0, err_proto}, 32'h1);
    core_rd(16'h0005);
    cmp("proto_write", {16'h0, bus.DataIn}, 32'hBEEF);

    // Write then immediate read
    core_wr(16'h0007, 16'h0707);
    core_rd(16'h0007);
    cmp("wr_then_rd", {16'h0, bus.DataIn}, 32'h0707);
    idle();

    // Overflow tracking and saturation
    for (int p = 0; p < 3; p++) begin
      bus.V = 1; tick(); tick();
      bus.V = 0; tick(); tick();
    end
    cmp("ovf_three", {24'h0, ovf_count}, 32'd3);
    cmp("ovf_sticky", {31'h0, ovf_sticky}, 32'h1);
    for (int p = 0; p < 300; p++) begin
      bus.V = 1; tick();
      bus.V = 0; tick();
    end
    cmp("ovf_sat", {24'h0, ovf_count}, 32'd255);
    cmp("ovf_sat_sticky", {31'h0, ovf_sticky}, 32'h1);

    // Reset in the middle of a burst; strobes in the Reset cycle are dropped
    core_rd(16'h0010);
    Reset = 1; bus.RD = 1; bus.WR = 1; bus.Addr = 16'h0012; bus.DataOut = 16'hDEAD;
    tick();
    cmp("mid_reset_DataIn", {16'h0, bus.DataIn}, 32'h0);
    cmp("mid_reset_proto", {31'h0, err_proto}, 32'h0);
    cmp("mid_reset_count", {24'h0, ovf_count}, 32'h0);
    idle();
    Reset = 0;
    core_rd(16'h0012);
    cmp("reset_kept_burst", {16'h0, bus.DataIn}, 32'h3C02);
    core_rd(16'h0007);
    cmp("reset_kept_wr", {16'h0, bus.DataIn}, 32'h0707);
    idle();

    // Upper address bits: aliasing or out-of-range flagging
    core_wr(16'h0405, 16'h1111);
    core_rd(16'h0405);
`ifdef CVP14_MEM_CHECK_EN
    cmp("oob_rd", {16'h0, bus.DataIn}, 32'h0);
    cmp("oob_flag", {31'h0, err_oob}, 32'h1);
    core_rd(16'h0005);
    cmp("oob_kept", {16'h0, bus.DataIn}, 32'hBEEF);
`else
    cmp("alias_rd", {16'h0, bus.DataIn}, 32'h1111);
    cmp("alias_flag", {31'h0, err_oob}, 32'h0);
    core_rd(16'h0005);
    cmp("alias_wr", {16'h0, bus.DataIn}, 32'h1111);
`endif
    idle();
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/cvp14_mem_sys.md
# cvp14_mem_sys

Unified 16-bit word-addressed memory subsystem sitting directly downstream of the CVP14 core bus (Addr/RD/WR/V/dataOut) and producing the core's DataIn. Provides a one-cycle registered read that matches the core's Fetch→Decode and Load-state timing. Includes a testbench/boot loader port that writes words when the core is idle, and sticky status capturing core overflow (V) and bus protocol errors.

## Interface
- ADDR_W, 10, implemented address bits; array depth 2^ADDR_W words
- OVF_CNT_W, 8, width of saturating overflow-event counter
- Clk1  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high
- Addr  in  16  core word address
- RD  in  1  core read strobe
- WR  in  1  core write strobe
- V  in  1  core overflow flag (level, updated on Fetch)
- DataOut  in  16  core write data
- DataIn  out  16  registered read data to core
- ld_valid  in  1  loader write request
- ld_ready  out  1  loader request accepted this cycle when high with ld_valid
- ld_addr  in  16  loader word address
- ld_data  in  16  loader write data
- ovf_sticky  out  1  V seen high since reset
- ovf_count  out  OVF_CNT_W  rising edges of V, saturating
- err_proto  out  1  sticky: RD and WR asserted in same cycle
- err_oob  out  1  sticky: out-of-range access (only with CVP14_MEM_CHECK_EN)

## Operation
- Array: 2^ADDR_W x 16, not cleared by Reset; contents survive Reset.
- Index = Addr[ADDR_W-1:0] (and ld_addr[ADDR_W-1:0]).
- Core read (RD=1, WR=0, Reset=0): DataIn <= mem[index] at the edge. DataIn holds its value in all cycles without a core read.
- Core write (WR=1, Reset=0): mem[index] <= DataOut at the edge; DataIn unchanged.
- RD=1 and WR=1 together: write performed, read suppressed (DataIn holds), err_proto <= 1.
- Loader: ld_ready = Reset | (~RD & ~WR), combinational. Accepted (ld_valid & ld_ready): mem[ld index] <= ld_data. Core access always wins; loader stalls with ld_valid held.
- Core strobes ignored while Reset=1 (no read, no write, no error flags).
- V tracking: register v_q <= V each non-reset cycle. V=1 → ovf_sticky <= 1. V=1 & v_q=0 → ovf_count + 1, saturating at all-ones.
- Status flags and counter only clear on Reset.

## Timing
- Reset (synchronous): DataIn=0, ovf_sticky=0, ovf_count=0, err_proto=0, err_oob=0, v_q=0. ld_ready=1 throughout Reset.
- Read latency: exactly 1 cycle; address sampled at edge N, data on DataIn after edge N, valid for core sampling at edge N+1.
- Back-to-back reads (core Load state, address+cycles): one new word per cycle, fully pipelined, no bubbles.
- Write latency: 0 visible; read of same address in next cycle returns new data.
- Loader write then core read of same address next cycle returns loader data.
- Reset asserted mid-burst: strobe in the Reset cycle dropped; DataIn=0 after that edge; earlier completed writes retained.
- ovf_count at saturation: stays at max, ovf_sticky stays 1.

## Configuration
- CVP14_MEM_CHECK_EN defined: any core or loader access with address bits [15:ADDR_W] nonzero sets err_oob; such writes are dropped; such core reads load DataIn=0.
- Undefined: upper address bits ignored (aliasing wrap-around); err_oob tied to 0.

## Test plan
- Reset with ld_valid: load 0x0000←0x4123, 0x0001←0x8FFE during Reset, release -> core RD at 0x0000 gives DataIn=0x4123 one cycle later, 0x0001 gives 0x8FFE next.
- Core Load burst: RD at 0x0010..0x001F consecutive cycles (preloaded with 0x3C00+i) -> DataIn=0x3C00+i exactly one cycle after each address, no gaps.
- Arbitration: ld_valid held while core RD 3 cycles -> ld_ready=0 those cycles, write lands first idle cycle; core read unaffected.
- Protocol error: RD=WR=1 at 0x0005, DataOut=0xBEEF -> mem[5]=0xBEEF, DataIn unchanged, err_proto=1 until Reset.
- Overflow: V pulsed high 3 separate times (2 cycles each) -> ovf_count=3, ovf_sticky=1; 300 pulses with OVF_CNT_W=8 -> ovf_count=255.
- Range (ADDR_W=10): WR at 0x0405 with 0x1111 -> with CVP14_MEM_CHECK_EN err_oob=1, mem[5] unchanged, read 0x0405 gives 0; without, mem[5]=0x1111, err_oob=0.
